// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers per-digit hex values from scanned 7-segment lines (ports: clk, rst, seg_in, digit_sel, digits, digit_valid, out_valid/out_ready/out_idx/out_nibble stream, bad_seg, overflow; SEG7_CAP_DP_EN adds dp_in, dp_flags, out_dp)
module seg7_scan_capture #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
`ifdef SEG7_CAP_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_flags,
  output logic                    out_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_idx,
  output logic [3:0]              out_nibble,
  output logic                    bad_seg,
  output logic                    overflow
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0] seg_r, seg_p;
  logic [NUM_DIGITS-1:0] sel_r, sel_p;
  logic same, one_hot, restart, full, capture, pat_ok, load;
  logic [3:0] nib;
  logic [2:0] idx;
`ifdef SEG7_CAP_DP_EN
  logic dp_r, dp_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_r <= 1'b0;
      dp_p <= 1'b0;
    end else begin
      dp_r <= dp_in;
      dp_p <= dp_r;
    end
  end
  assign same = {seg_r, sel_r, dp_r} == {seg_p, sel_p, dp_p};
`else
  assign same = {seg_r, sel_r} == {seg_p, sel_p};
`endif
  // seg_r/sel_r are the sampled pins; seg_p/sel_p hold the previous sample for the stability compare
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      sel_r <= '0;
      seg_p <= '0;
      sel_p <= '0;
    end else begin
      seg_r <= seg_in;
      sel_r <= digit_sel;
      seg_p <= seg_r;
      sel_p <= sel_r;
    end
  end
  assign one_hot = $onehot(sel_r);
  assign full = cnt == FULL;
  assign restart = state == IDLE || !same;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = restart ? (one_hot ? SETTLE : IDLE) : (state == SETTLE && full ? HOLD : state);
    cnt_n = restart ? (one_hot ? CW'(1) : '0) : (full ? cnt : cnt + CW'(1));
  end
  always_comb begin
    capture = state == SETTLE && same && full;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (sel_r[i]) idx = 3'(i);
    nib = '0;
    pat_ok = 1'b1;
    case (seg_r)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: pat_ok = 1'b0;
    endcase
    load = capture && pat_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      digit_valid <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_nibble <= '0;
      bad_seg <= 1'b0;
      overflow <= 1'b0;
`ifdef SEG7_CAP_DP_EN
      dp_flags <= '0;
      out_dp <= 1'b0;
`endif
    end else begin
      bad_seg <= capture && !pat_ok;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load && idx == 3'(i)) begin
          digits[4*i +: 4] <= nib;
          digit_valid[i] <= 1'b1;
`ifdef SEG7_CAP_DP_EN
          dp_flags[i] <= dp_r;
`endif
        end
      end
      // the register file is always updated; only the stream entry can be dropped
      if (load && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_idx <= idx;
        out_nibble <= nib;
`ifdef SEG7_CAP_DP_EN
        out_dp <= dp_r;
`endif
      end else if (load) begin
        overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed self-checking bench for seg7_scan_capture
module tb_seg7_scan_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg_in = '0;
  logic [3:0] digit_sel = '0;
  logic [15:0] digits;
  logic [3:0] digit_valid;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2:0] out_idx;
  logic [3:0] out_nibble;
  logic bad_seg, overflow;
  int n_cmp = 0, n_err = 0, cyc = 0, first = -1, bad_n = 0;
  int acc_idx[$], acc_nib[$];
  logic [6:0] glyph [4] = '{7'h77, 7'h7C, 7'h39, 7'h5E};
  always #5 clk = ~clk;
  seg7_scan_capture dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel),
    .digits(digits), .digit_valid(digit_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_nibble(out_nibble),
    .bad_seg(bad_seg), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (out_valid === 1'b1 && out_ready) begin
        acc_idx.push_back(int'(out_idx));
        acc_nib.push_back(int'(out_nibble));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1 && first < 0) first = cyc;
      if (bad_seg === 1'b1) bad_n++;
    end
  endtask
  task automatic clr();
    cyc = 0;
    first = -1;
    bad_n = 0;
    acc_idx.delete();
    acc_nib.delete();
  endtask
  task automatic reset_outs_zero(input string tag);
    chk({tag, "_digits"}, 32'(digits), 0);
    chk({tag, "_dvalid"}, 32'(digit_valid), 0);
    chk({tag, "_ovalid"}, 32'(out_valid), 0);
    chk({tag, "_oidx"}, 32'(out_idx), 0);
    chk({tag, "_onib"}, 32'(out_nibble), 0);
    chk({tag, "_bad"}, 32'(bad_seg), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask
  initial begin
    @(negedge clk);
    run(3);
    reset_outs_zero("rst");
    rst = 1'b0;
    clr();
    digit_sel = 4'b0001;
    seg_in = 7'h4F;
    run(20);
    chk("t1_latency", first, 18);
    chk("t1_entries", acc_idx.size(), 1);
    if (acc_idx.size() > 0) begin
      chk("t1_idx", acc_idx[0], 0);
      chk("t1_nib", acc_nib[0], 3);
    end
    chk("t1_digit0", 32'(digits[3:0]), 3);
    chk("t1_dvalid", 32'(digit_valid), 4'b0001);
    chk("t1_bad", bad_n, 0);
    clr();
    for (int d = 0; d < 4; d++) begin
      digit_sel = 4'(1 << d);
      seg_in = glyph[d];
      run(17);
    end
    digit_sel = 4'b0000;
    run(5);
    chk("t2_digits", 32'(digits), 16'hDCBA);
    chk("t2_dvalid", 32'(digit_valid), 4'b1111);
    chk("t2_entries", acc_idx.size(), 4);
    for (int d = 0; d < 4 && d < acc_idx.size(); d++) begin
      chk($sformatf("t2_idx%0d", d), acc_idx[d], d);
      chk($sformatf("t2_nib%0d", d), acc_nib[d], 10 + d);
    end
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clr();
    digit_sel = 4'b0010;
    seg_in = 7'h7E;
    run(20);
    chk("t3_bad", bad_n, 1);
    chk("t3_ovalid", first, -1);
    chk("t3_dvalid", 32'(digit_valid), 0);
    clr();
    for (int k = 0; k < 6; k++) begin
      seg_in = k[0] ? 7'h5B : 7'h06;
      run(10);
    end
    chk("t4_toggle_ovalid", first, -1);
    chk("t4_toggle_bad", bad_n, 0);
    chk("t4_toggle_dvalid", 32'(digit_valid), 0);
    digit_sel = 4'b0011;
    seg_in = 7'h06;
    run(40);
    chk("t4_multi_ovalid", first, -1);
    chk("t4_multi_bad", bad_n, 0);
    chk("t4_multi_dvalid", 32'(digit_valid), 0);
    clr();
    out_ready = 1'b0;
    digit_sel = 4'b0001;
    seg_in = 7'h06;
    run(20);
    chk("t5_ovf_before", 32'(overflow), 0);
    seg_in = 7'h5B;
    run(20);
    chk("t5_ovalid", 32'(out_valid), 1);
    chk("t5_nib", 32'(out_nibble), 1);
    chk("t5_idx", 32'(out_idx), 0);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_digit0", 32'(digits[3:0]), 2);
    chk("t5_no_accept", acc_idx.size(), 0);
    out_ready = 1'b1;
    run(5);
    chk("t5_accepted", acc_idx.size(), 1);
    if (acc_nib.size() > 0) chk("t5_acc_nib", acc_nib[0], 1);
    chk("t5_ovalid_after", 32'(out_valid), 0);
    clr();
    seg_in = 7'h4F;
    run(11);
    chk("t6_no_early", first, -1);
    rst = 1'b1;
    run(3);
    reset_outs_zero("t6_rst");
    rst = 1'b0;
    clr();
    run(20);
    chk("t6_latency", first, 18);
    chk("t6_entries", acc_idx.size(), 1);
    if (acc_nib.size() > 0) chk("t6_nib", acc_nib[0], 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
